// File: rtl/keypad_scan_encoder_pkg.sv
// Shared types and constants for the 4x4 keypad scan/debounce encoder.
package keypad_pkg;

    localparam int KEY_W    = 4;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    // Column 0 driven low, others released.
    localparam logic [NUM_COLS-1:0] COL_RESET = 4'b1110;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } kp_state_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } frame_res_t;

    // Active-low one-hot drive pattern for a column index.
    function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Number of pressed rows in one column, saturating at 2 ("two or more").
    function automatic logic [1:0] row_hits(input logic [NUM_ROWS-1:0] pressed);
        logic [1:0] n;
        n = 2'd0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (pressed[r] && (n != 2'd2)) begin
                n = n + 2'd1;
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    // Index of the lowest pressed row (meaningful only when exactly one is pressed).
    function automatic logic [1:0] row_index(input logic [NUM_ROWS-1:0] pressed);
        logic [1:0] idx;
        idx = 2'd0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (pressed[r]) begin
                idx = 2'(r);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_col_scanner.sv
// Column scan timing: drives one column low per SCAN_DIV-cycle window and
// flags the row-sample cycle (last of each window) and the frame end.
module keypad_col_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic                clk,
    input  logic                reset,
    output logic [NUM_COLS-1:0] col_o,
    output logic                sample_en,
    output logic [1:0]          col_idx,
    output logic                frame_end
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0]    div_r;
    logic [1:0]          col_r;
    logic [NUM_COLS-1:0] col_drv_r;

    assign sample_en = (div_r == DIV_LAST);
    assign frame_end = sample_en && (col_r == 2'd3);
    assign col_idx   = col_r;
    assign col_o     = col_drv_r;

    // Divider and column advance; the drive pattern is registered with the index.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r     <= '0;
            col_r     <= 2'd0;
            col_drv_r <= COL_RESET;
        end else if (sample_en) begin
            div_r     <= '0;
            col_r     <= col_r + 2'd1;
            col_drv_r <= col_drive(col_r + 2'd1);
        end else begin
            div_r     <= div_r + DIV_W'(1);
        end
    end

endmodule

// File: rtl/keypad_scan_encoder.sv
// 4x4 active-low keypad scanner with frame-based debounce and a valid/ack
// output handshake carrying a {row, col} hex code.
module keypad_scan_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] row_i,
    output logic [NUM_COLS-1:0] col_o,
    output logic [KEY_W-1:0]    key_code,
    output logic                key_valid,
    input  logic                key_ack,
    output logic                key_held,
    output logic                overrun
);

    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CNT_W-1:0] DEB_CNT = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic                sample_en_s;
    logic                frame_end_s;
    logic [1:0]          col_idx_s;

    logic [NUM_ROWS-1:0] row_meta_r;
    logic [NUM_ROWS-1:0] row_sync_r;

    logic [1:0]          acc_hits_r;
    logic [KEY_W-1:0]    acc_code_r;
    logic [1:0]          col_hits_s;
    logic [2:0]          hit_sum_s;
    logic [1:0]          merged_hits_s;
    logic [KEY_W-1:0]    merged_code_s;
    frame_res_t          frame_res_s;

    kp_state_t           state_r, state_nxt;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt;
    logic [KEY_W-1:0]    cand_r, cand_nxt;
    logic                accept_s;

    logic [KEY_W-1:0]    key_code_r;
    logic                key_valid_r;
    logic                key_held_r;
    logic                overrun_r;

    keypad_col_scanner #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scanner (
        .clk       (clk),
        .reset     (reset),
        .col_o     (col_o),
        .sample_en (sample_en_s),
        .col_idx   (col_idx_s),
        .frame_end (frame_end_s)
    );

    // Two-flop synchronizer for the asynchronous row inputs; idle rows read high.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta_r <= 4'b1111;
            row_sync_r <= 4'b1111;
        end else begin
            row_meta_r <= row_i;
            row_sync_r <= row_meta_r;
        end
    end

    // Fold the current column's sampled rows into the running frame result.
    always_comb begin
        col_hits_s    = row_hits(~row_sync_r);
        hit_sum_s     = {1'b0, acc_hits_r} + {1'b0, col_hits_s};
        merged_hits_s = (hit_sum_s >= 3'd2) ? 2'd2 : hit_sum_s[1:0];
        if ((acc_hits_r == 2'd0) && (col_hits_s == 2'd1)) begin
            merged_code_s = {row_index(~row_sync_r), col_idx_s};
        end else begin
            merged_code_s = acc_code_r;
        end
        case (merged_hits_s)
            2'd0:    frame_res_s = NONE;
            2'd1:    frame_res_s = SINGLE;
            default: frame_res_s = MULTI;
        endcase
    end

    // Frame accumulator: cleared at every frame end so each frame starts fresh.
    always_ff @(posedge clk) begin
        if (reset || frame_end_s) begin
            acc_hits_r <= 2'd0;
            acc_code_r <= '0;
        end else if (sample_en_s) begin
            acc_hits_r <= merged_hits_s;
            acc_code_r <= merged_code_s;
        end else begin
            acc_hits_r <= acc_hits_r;
            acc_code_r <= acc_code_r;
        end
    end

    // Debounce next-state logic, evaluated only on the frame-end cycle.
    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        cand_nxt  = cand_r;
        accept_s  = 1'b0;
        if (frame_end_s) begin
            case (state_r)
                IDLE: begin
                    if (frame_res_s == SINGLE) begin
                        cand_nxt = merged_code_s;
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_nxt = HELD;
                            cnt_nxt   = '0;
                            accept_s  = 1'b1;
                        end else begin
                            state_nxt = PRESS_WAIT;
                            cnt_nxt   = CNT_ONE;
                        end
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                PRESS_WAIT: begin
                    if (frame_res_s == SINGLE) begin
                        if (merged_code_s == cand_r) begin
                            if ((cnt_r + CNT_ONE) == DEB_CNT) begin
                                state_nxt = HELD;
                                cnt_nxt   = '0;
                                accept_s  = 1'b1;
                            end else begin
                                cnt_nxt = cnt_r + CNT_ONE;
                            end
                        end else begin
                            cand_nxt = merged_code_s;
                            cnt_nxt  = CNT_ONE;
                        end
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                HELD: begin
                    if (frame_res_s == NONE) begin
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = RELEASE_WAIT;
                            cnt_nxt   = CNT_ONE;
                        end
                    end else begin
                        state_nxt = HELD;
                    end
                end
                RELEASE_WAIT: begin
                    if (frame_res_s == NONE) begin
                        if ((cnt_r + CNT_ONE) == DEB_CNT) begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt_r + CNT_ONE;
                        end
                    end else begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end else begin
            state_nxt = state_r;
        end
    end

    // FSM state register plus registered held flag and output handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            cand_r      <= '0;
            key_code_r  <= '0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt;
            cnt_r      <= cnt_nxt;
            cand_r     <= cand_nxt;
            key_held_r <= (state_nxt == HELD) || (state_nxt == RELEASE_WAIT);
            if (accept_s) begin
                key_code_r  <= cand_nxt;
                key_valid_r <= 1'b1;
                // An ack in the same cycle consumes the old code, so no overrun.
                if (key_ack && key_valid_r) begin
                    overrun_r <= 1'b0;
                end else if (key_valid_r) begin
                    overrun_r <= 1'b1;
                end else begin
                    overrun_r <= overrun_r;
                end
            end else if (key_ack && key_valid_r) begin
                key_valid_r <= 1'b0;
                overrun_r   <= 1'b0;
            end else begin
                key_valid_r <= key_valid_r;
                overrun_r   <= overrun_r;
            end
        end
    end

    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Self-checking bench for keypad_scan_encoder: frame-level vector table,
// hand-written bounce / reset sequences, and a randomized run against a
// run-length reference model of the debounce rules.
module tb_keypad_scan_encoder;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic       clk;
    logic       reset;
    logic [3:0] row_i;
    logic [3:0] col_o;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       key_held;
    logic       overrun;

    logic [15:0] press_mask;   // bit (row*4+col) set = that key is pressed

    int vectors;
    int miscompares;

    keypad_scan_encoder #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_FRAMES (DEB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_i     (row_i),
        .col_o     (col_o),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Passive matrix: a row reads low when a pressed key sits on a driven-low column.
    always_comb begin
        row_i = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (press_mask[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
            end
        end
    end

    typedef struct {
        logic [15:0] mask;
        int          ack_at;
        logic        valid;
        logic [3:0]  code;
        logic        held;
        logic        ovr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst col_o", {12'h0, col_o}, 16'h000E);
        check("rst key_valid", {15'h0, key_valid}, 16'h0);
        check("rst key_code", {12'h0, key_code}, 16'h0);
        check("rst key_held", {15'h0, key_held}, 16'h0);
        check("rst overrun", {15'h0, overrun}, 16'h0);
    endtask

    // Hold reset 3 cycles, check, release; returns at cycle 0 of the first frame.
    task automatic do_reset();
        reset   = 1'b1;
        key_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b0;
    endtask

    // One full frame: mask applied from its first cycle, optional one-cycle ack.
    task automatic apply_frame(input logic [15:0] mask, input int ack_at);
        for (int t = 0; t < FRAME; t++) begin
            if (t == 0) press_mask = mask;
            key_ack = (t == ack_at);
            @(posedge clk);
            #1;
        end
        key_ack = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic v, input logic [3:0] c,
                                 input logic h, input logic o);
        check({tag, " valid"}, {15'h0, key_valid}, {15'h0, v});
        check({tag, " code"}, {12'h0, key_code}, {12'h0, c});
        check({tag, " held"}, {15'h0, key_held}, {15'h0, h});
        check({tag, " overrun"}, {15'h0, overrun}, {15'h0, o});
    endtask

    function automatic vec_t mk(input logic [15:0] m, input int a, input logic v,
                                input logic [3:0] c, input logic h, input logic o);
        vec_t x;
        x.mask = m; x.ack_at = a; x.valid = v; x.code = c; x.held = h; x.ovr = o;
        return x;
    endfunction

    // Reference model state (run-length view of the debounce rules)
    bit         m_held;
    int         m_run;
    logic [3:0] m_key;
    int         m_none;
    logic       m_valid;
    logic [3:0] m_code;
    logic       m_ovr;

    task automatic model_frame(input logic [15:0] mask, input int ack_at);
        bit ack_eff;
        bit accept;
        int k;
        if (ack_at >= 0 && ack_at < FRAME - 1 && m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        ack_eff = (ack_at == FRAME - 1) && m_valid;
        accept  = 1'b0;
        k = 0;
        for (int i = 0; i < 16; i++) if (mask[i]) k = i;
        if (!m_held) begin
            if ($countones(mask) == 1) begin
                if (m_run > 0 && 4'(k) == m_key) m_run++;
                else begin m_run = 1; m_key = 4'(k); end
                if (m_run == DEB) begin
                    accept = 1'b1; m_held = 1'b1; m_run = 0; m_none = 0;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if ($countones(mask) == 0) begin
                m_none++;
                if (m_none == DEB) begin m_held = 1'b0; m_none = 0; m_run = 0; end
            end else begin
                m_none = 0;
            end
        end
        if (accept) begin
            if (ack_eff) m_ovr = 1'b0;
            else if (m_valid) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_code  = m_key;
        end else if (ack_eff) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    initial begin
        int rise_cnt;
        int rise_t;
        logic prev_v;
        logic [15:0] cur_mask;
        int ack_at;
        int r;

        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        key_ack     = 1'b0;
        press_mask  = 16'h0;

        // ---------------- table-driven frame sequence ----------------
        vecs.push_back(mk(16'h0200, -1, 1'b0, 4'h0, 1'b0, 1'b0)); // clean press of 0x9
        vecs.push_back(mk(16'h0200, -1, 1'b0, 4'h0, 1'b0, 1'b0));
        vecs.push_back(mk(16'h0200, -1, 1'b1, 4'h9, 1'b1, 1'b0));
        vecs.push_back(mk(16'h0200,  5, 1'b0, 4'h9, 1'b1, 1'b0)); // ack
        vecs.push_back(mk(16'h0000, -1, 1'b0, 4'h9, 1'b1, 1'b0)); // release
        vecs.push_back(mk(16'h0000, -1, 1'b0, 4'h9, 1'b1, 1'b0));
        vecs.push_back(mk(16'h0000, -1, 1'b0, 4'h9, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++)                                // multi 0x0+0x3
            vecs.push_back(mk(16'h0009, -1, 1'b0, 4'h9, 1'b0, 1'b0));
        for (int i = 0; i < 2; i++)                                // multi, same column
            vecs.push_back(mk(16'h0011, -1, 1'b0, 4'h9, 1'b0, 1'b0));
        vecs.push_back(mk(16'h0001, -1, 1'b0, 4'h9, 1'b0, 1'b0)); // 0x0 alone
        vecs.push_back(mk(16'h0001, -1, 1'b0, 4'h9, 1'b0, 1'b0));
        vecs.push_back(mk(16'h0001, -1, 1'b1, 4'h0, 1'b1, 1'b0));
        vecs.push_back(mk(16'h0000, -1, 1'b1, 4'h0, 1'b1, 1'b0)); // release, no ack
        vecs.push_back(mk(16'h0000, -1, 1'b1, 4'h0, 1'b1, 1'b0));
        vecs.push_back(mk(16'h0000, -1, 1'b1, 4'h0, 1'b0, 1'b0));
        vecs.push_back(mk(16'h8000, -1, 1'b1, 4'h0, 1'b0, 1'b0)); // 0xF -> overrun
        vecs.push_back(mk(16'h8000, -1, 1'b1, 4'h0, 1'b0, 1'b0));
        vecs.push_back(mk(16'h8000, -1, 1'b1, 4'hF, 1'b1, 1'b1));
        vecs.push_back(mk(16'h8000,  5, 1'b0, 4'hF, 1'b1, 1'b0)); // ack clears both
        vecs.push_back(mk(16'h0000, -1, 1'b0, 4'hF, 1'b1, 1'b0));
        vecs.push_back(mk(16'h0000, -1, 1'b0, 4'hF, 1'b1, 1'b0));
        vecs.push_back(mk(16'h0000, -1, 1'b0, 4'hF, 1'b0, 1'b0));
        vecs.push_back(mk(16'h0020, -1, 1'b0, 4'hF, 1'b0, 1'b0)); // 0x5, left pending
        vecs.push_back(mk(16'h0020, -1, 1'b0, 4'hF, 1'b0, 1'b0));
        vecs.push_back(mk(16'h0020, -1, 1'b1, 4'h5, 1'b1, 1'b0));
        vecs.push_back(mk(16'h0000, -1, 1'b1, 4'h5, 1'b1, 1'b0));
        vecs.push_back(mk(16'h0000, -1, 1'b1, 4'h5, 1'b1, 1'b0));
        vecs.push_back(mk(16'h0000, -1, 1'b1, 4'h5, 1'b0, 1'b0));
        vecs.push_back(mk(16'h0040, -1, 1'b1, 4'h5, 1'b0, 1'b0)); // 0x6, ack on accept cycle
        vecs.push_back(mk(16'h0040, -1, 1'b1, 4'h5, 1'b0, 1'b0));
        vecs.push_back(mk(16'h0040, 15, 1'b1, 4'h6, 1'b1, 1'b0));
        for (int i = 0; i < 3; i++)                                // change while held: ignored
            vecs.push_back(mk(16'h0080, -1, 1'b1, 4'h6, 1'b1, 1'b0));
        vecs.push_back(mk(16'h0080,  5, 1'b0, 4'h6, 1'b1, 1'b0));

        do_reset();
        foreach (vecs[i]) begin
            apply_frame(vecs[i].mask, vecs[i].ack_at);
            check_outputs($sformatf("vec%0d", i), vecs[i].valid, vecs[i].code,
                          vecs[i].held, vecs[i].ovr);
        end

        // ---------------- column stepping + bounce ----------------
        press_mask = 16'h0;
        do_reset();
        rise_cnt = 0;
        rise_t   = -1;
        prev_v   = key_valid;
        for (int t = 0; t < 160; t++) begin
            if (t <= 16 && (t % SCAN_DIV) == 0)
                check($sformatf("col step t%0d", t), {12'h0, col_o},
                      {12'h0, ~(4'b0001 << ((t / SCAN_DIV) % 4))});
            if (key_valid && !prev_v) begin
                rise_cnt++;
                if (rise_t < 0) rise_t = t;
            end
            prev_v = key_valid;
            press_mask = (t < 40 && ((t / 10) % 2) == 1) ? 16'h0000 : 16'h0020;
            @(posedge clk);
            #1;
        end
        check("bounce accept count", 16'(rise_cnt), 16'd1);
        check("bounce accept time", 16'(rise_t), 16'd96);
        check("bounce code", {12'h0, key_code}, 16'h0005);

        // ---------------- reset mid-debounce ----------------
        press_mask = 16'h0;
        do_reset();
        apply_frame(16'h0080, -1);
        apply_frame(16'h0080, -1);
        check_outputs("pre-reset", 1'b0, 4'h0, 1'b0, 1'b0);
        do_reset();                       // key 0x7 still held throughout
        apply_frame(16'h0080, -1);
        check_outputs("post-reset f1", 1'b0, 4'h0, 1'b0, 1'b0);
        apply_frame(16'h0080, -1);
        check_outputs("post-reset f2", 1'b0, 4'h0, 1'b0, 1'b0);
        apply_frame(16'h0080, -1);
        check_outputs("post-reset f3", 1'b1, 4'h7, 1'b1, 1'b0);

        // ---------------- randomized vs reference model ----------------
        press_mask = 16'h0;
        do_reset();
        m_held = 1'b0; m_run = 0; m_key = 4'h0; m_none = 0;
        m_valid = 1'b0; m_code = 4'h0; m_ovr = 1'b0;
        cur_mask = 16'h0;
        for (int f = 0; f < 300; f++) begin
            if ($urandom_range(0, 9) < 3) begin
                r = $urandom_range(0, 9);
                if (r < 4)      cur_mask = 16'h0;
                else if (r < 9) cur_mask = 16'h1 << $urandom_range(0, 15);
                else            cur_mask = (16'h1 << $urandom_range(0, 15)) |
                                           (16'h1 << $urandom_range(0, 15));
            end
            r = $urandom_range(0, 9);
            ack_at = (r < 6) ? -1 : ((r < 8) ? 5 : FRAME - 1);
            apply_frame(cur_mask, ack_at);
            model_frame(cur_mask, ack_at);
            check_outputs($sformatf("rnd%0d", f), m_valid, m_code, m_held, m_ovr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
